ssid_lookup_responder: RTL and testbench

//  Responder end of the SSID/newAddress address stream: sink for the address counter.
//  - Accepts one SSID per newAddress strobe while storageReady is high.
//  - Reads the hit memory word at that SSID (fixed read latency).
//  - Returns {SSID, data} downstream on a valid/ready handshake.
//  - Drives storageReady as the flow-control signal back to the address source.

---
 rtl/ssid_lookup_responder_pkg.sv | 14 +
 rtl/ssid_sync_fifo.sv | 54 +++++
 rtl/ssid_lookup_responder.sv | 135 +++++++++++++
 tb/tb_ssid_lookup_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssid_lookup_responder_pkg.sv
// Shared widths and result word layout for the SSID lookup responder.
package ssid_lookup_responder_pkg;

  localparam int unsigned DEF_SSIDBITS = 8;
  localparam int unsigned DEF_DATABITS = 16;
  localparam int unsigned RESULT_W     = DEF_SSIDBITS + DEF_DATABITS;

  // Result word as it leaves the responder: {SSID, data}
  typedef struct packed {
    logic [DEF_SSIDBITS-1:0] ssid;
    logic [DEF_DATABITS-1:0] data;
  } result_t;

endpackage

// File: rtl/ssid_sync_fifo.sv
// Synchronous FIFO with occupancy count; any depth >= 1, async active-high reset.
// Read data is forced to zero while empty so downstream outputs stay quiet.
module ssid_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  assign empty    = (count == '0);
  assign do_push  = push && (count < CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array, written on accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ssid_lookup_responder.sv
// Responder for the SSID/newAddress stream: queues SSIDs, reads the hit memory,
// returns {SSID, data} on a valid/ready port. Credits sized to the result FIFO
// guarantee memory returns always have room, so memory never sees back-pressure.
// Optional build macro SKIP_EMPTY_EN: memory words equal to zero produce no result.
module ssid_lookup_responder
  import ssid_lookup_responder_pkg::*;
#(
  parameter int unsigned SSIDBITS    = DEF_SSIDBITS,
  parameter int unsigned DATABITS    = DEF_DATABITS,
  parameter int unsigned REQ_DEPTH   = 4,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                newAddress,
  input  logic [SSIDBITS-1:0] SSID,
  output logic                storageReady,
  output logic                memReadEn,
  output logic [SSIDBITS-1:0] memReadAddr,
  input  logic [DATABITS-1:0] memReadData,
  output logic                outValid,
  input  logic                outReady,
  output logic [SSIDBITS-1:0] outSSID,
  output logic [DATABITS-1:0] outData,
  output logic                overflow
);

  localparam int unsigned RES_DEPTH = MEM_LATENCY + 1;
  localparam int unsigned RES_W     = SSIDBITS + DATABITS;
  localparam int unsigned REQ_CW    = $clog2(REQ_DEPTH + 1);
  localparam int unsigned RES_CW    = $clog2(RES_DEPTH + 1);
  localparam int unsigned NW        = REQ_CW + 1;
  localparam int unsigned CRED_W    = RES_CW + 1;

  logic                accept;
  logic                req_pop;
  logic [SSIDBITS-1:0] req_head;
  logic [REQ_CW-1:0]   req_count;
  logic                req_empty;

  logic                res_push;
  logic                res_pop;
  logic [RES_W-1:0]    res_word_in;
  logic [RES_W-1:0]    res_word_out;
  logic [RES_CW-1:0]   res_count;
  logic                res_empty;

  logic [MEM_LATENCY-1:0]               pipe_vld;
  logic [MEM_LATENCY-1:0][SSIDBITS-1:0] pipe_ssid;
  logic                                 tail_vld;
  logic                                 skip;
  logic [RES_CW-1:0]                    in_flight;
  logic                                 issue_ok;
  logic [NW-1:0]                        req_next;
  logic                                 ready_d;

  assign accept = newAddress && storageReady;

  ssid_sync_fifo #(.WIDTH(SSIDBITS), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (SSID),
    .pop       (req_pop),
    .pop_data  (req_head),
    .count     (req_count),
    .empty     (req_empty)
  );

  ssid_sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (res_push),
    .push_data (res_word_in),
    .pop       (res_pop),
    .pop_data  (res_word_out),
    .count     (res_count),
    .empty     (res_empty)
  );

  assign tail_vld = pipe_vld[MEM_LATENCY-1];

`ifdef SKIP_EMPTY_EN
  assign skip = tail_vld && (memReadData == '0);
`else
  assign skip = 1'b0;
`endif

  assign res_push    = tail_vld && !skip;
  assign res_word_in = {pipe_ssid[MEM_LATENCY-1], memReadData};

  assign outValid           = !res_empty;
  assign res_pop            = outValid && outReady;
  assign {outSSID, outData} = res_word_out;

  assign memReadEn   = req_pop;
  assign memReadAddr = req_pop ? req_head : '0;

  // Issue gating: a slot freed by an output pop or a skipped return is reusable this cycle
  always_comb begin
    in_flight = RES_CW'($countones(pipe_vld));
    issue_ok  = (CRED_W'(in_flight) + CRED_W'(res_count))
              < (CRED_W'(RES_DEPTH) + CRED_W'(res_pop) + CRED_W'(skip));
    req_pop   = !req_empty && issue_ok;
  end

  // Flow control: ready when next-cycle request occupancy leaves room
  always_comb begin
    req_next = NW'(req_count) + NW'(accept) - NW'(req_pop);
    ready_d  = (req_next < NW'(REQ_DEPTH));
  end

  // Read latency shift register carrying the issued SSID to the memory return
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_vld  <= '0;
      pipe_ssid <= '0;
    end else begin
      pipe_vld  <= MEM_LATENCY'({pipe_vld, req_pop});
      pipe_ssid <= (MEM_LATENCY * SSIDBITS)'({pipe_ssid, req_head});
    end
  end

  // Registered ready and sticky overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      storageReady <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      storageReady <= ready_d;
      if (newAddress && !storageReady) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssid_lookup_responder.sv
// Scoreboard bench for ssid_lookup_responder; memory model word[a] = {8'hA5, a},
// except SSID 8'h10 which reads as zero. Honors SKIP_EMPTY_EN like the design.
module tb_ssid_lookup_responder;
  import ssid_lookup_responder_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        newAddress;
  logic [7:0]  SSID;
  logic        storageReady;
  logic        memReadEn;
  logic [7:0]  memReadAddr;
  logic [15:0] memReadData;
  logic        outValid;
  logic        outReady;
  logic [7:0]  outSSID;
  logic [15:0] outData;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_pop    = 0;

  result_t exp_q[$];

  ssid_lookup_responder #(
    .SSIDBITS(8), .DATABITS(16), .REQ_DEPTH(4), .MEM_LATENCY(LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .newAddress   (newAddress),
    .SSID         (SSID),
    .storageReady (storageReady),
    .memReadEn    (memReadEn),
    .memReadAddr  (memReadAddr),
    .memReadData  (memReadData),
    .outValid     (outValid),
    .outReady     (outReady),
    .outSSID      (outSSID),
    .outData      (outData),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return (a == 8'h10) ? 16'h0000 : {8'hA5, a};
  endfunction

  // Memory model: fixed read latency, junk when no read is returning
  logic       mq_v [LAT];
  logic [7:0] mq_a [LAT];
  always @(posedge clock) begin
    mq_v[0] <= memReadEn;
    mq_a[0] <= memReadAddr;
    for (int i = 1; i < LAT; i++) begin
      mq_v[i] <= mq_v[i-1];
      mq_a[i] <= mq_a[i-1];
    end
  end
  always_comb memReadData = (mq_v[LAT-1] === 1'b1) ? mem_word(mq_a[LAT-1]) : 16'hDEAD;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: each accepted result must match the scoreboard head
  always @(negedge clock) begin
    if (outValid === 1'b1 && outReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(outValid), 32'd0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check_eq("out_ssid", 32'(outSSID), 32'(e.ssid));
        check_eq("out_data", 32'(outData), 32'(e.data));
        last_pop = cyc;
      end
    end
  end

  function automatic bit expect_result(input logic [7:0] s);
`ifdef SKIP_EMPTY_EN
    return mem_word(s) != 16'h0000;
`else
    return 1'b1;
`endif
  endfunction

  // Drive one strobe for one cycle; record expectation when bench predicts acceptance
  task automatic strobe(input logic [7:0] s, input bit acc);
    newAddress = 1'b1;
    SSID       = s;
    if (acc && expect_result(s)) exp_q.push_back('{ssid: s, data: mem_word(s)});
    @(posedge clock); #1;
    newAddress = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int start;
    reset      = 1'b1;
    newAddress = 1'b0;
    SSID       = 8'h00;
    outReady   = 1'b1;

    // Reset state
    #3;
    check_eq("rst_ready",  32'(storageReady), 32'd0);
    check_eq("rst_valid",  32'(outValid),     32'd0);
    check_eq("rst_memen",  32'(memReadEn),    32'd0);
    check_eq("rst_ovf",    32'(overflow),     32'd0);
    #9 reset = 1'b0;
    #1 check_eq("rel_ready0", 32'(storageReady), 32'd0);
    @(posedge clock); #1;
    check_eq("rel_ready1", 32'(storageReady), 32'd1);

    // 1: single lookup, address and latency
    strobe(8'h37, 1'b1);
    check_eq("t1_memen", 32'(memReadEn),   32'd1);
    check_eq("t1_addr",  32'(memReadAddr), 32'h37);
    n = 1;
    while (outValid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    check_eq("t1_latency", 32'(n), 32'd4);
    drain("t1_drain");
    idle(3);

    // 2: 23 back-to-back strobes, full throughput
    start = cyc;
    for (int i = 0; i < 23; i++) begin
      check_eq("t2_ready", 32'(storageReady), 32'd1);
      strobe(8'(8'h40 + i), 1'b1);
    end
    drain("t2_drain");
    check_eq("t2_thru", 32'(last_pop - start), 32'd26);
    check_eq("t2_ovf",  32'(overflow), 32'd0);
    idle(3);

    // 3: stalled output fills credits then the request FIFO
    outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("t3_ready", 32'(storageReady), (i < 7) ? 32'd1 : 32'd0);
      strobe(8'(8'h80 + i), i < 7);
    end
    check_eq("t3_ovf", 32'(overflow), 32'd1);
    idle(4);
    check_eq("t3_hold_v", 32'(outValid), 32'd1);
    check_eq("t3_hold_s", 32'(outSSID),  32'h80);
    idle(1);
    check_eq("t3_hold_s2", 32'(outSSID), 32'h80);
    check_eq("t3_hold_d2", 32'(outData), 32'hA580);
    outReady = 1'b1;
    drain("t3_drain");
    idle(3);

    // 4: reset with work queued and in flight
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) strobe(8'(8'hC0 + i), 1'b0);
    reset = 1'b1;
    #1;
    check_eq("t4_valid", 32'(outValid),     32'd0);
    check_eq("t4_memen", 32'(memReadEn),    32'd0);
    check_eq("t4_addr",  32'(memReadAddr),  32'd0);
    check_eq("t4_ssid",  32'(outSSID),      32'd0);
    check_eq("t4_data",  32'(outData),      32'd0);
    check_eq("t4_ready", 32'(storageReady), 32'd0);
    check_eq("t4_ovf",   32'(overflow),     32'd0);
    outReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("t4_ready1", 32'(storageReady), 32'd1);
    idle(10);
    check_eq("t4_stale", 32'(outValid), 32'd0);

    // 5: zero memory word in the middle of a stream
    strobe(8'h0F, 1'b1);
    strobe(8'h10, 1'b1);
    strobe(8'h11, 1'b1);
    drain("t5_drain");
    idle(6);
    check_eq("t5_ovf", 32'(overflow), 32'd0);

    // 6: push and pop together at REQ_DEPTH-1 queued
    outReady = 1'b0;
    for (int i = 0; i < 6; i++) strobe(8'(8'hD0 + i), 1'b1);
    idle(3);
    check_eq("t6_pre", 32'(storageReady), 32'd1);
    outReady = 1'b1;
    strobe(8'hD6, 1'b1);
    outReady = 1'b0;
    check_eq("t6_hold", 32'(storageReady), 32'd1);
    strobe(8'hD7, 1'b1);
    check_eq("t6_full", 32'(storageReady), 32'd0);
    check_eq("t6_ovf",  32'(overflow),     32'd0);
    outReady = 1'b1;
    drain("t6_drain");
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
